// File: rtl/mul_issue_ctrl_if.sv
// Request/response bundle between execute, the multiply sequencer and writeback.
// master = execute/writeback side, slave = mul_issue_ctrl.
interface mul_issue_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_funct3;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic [4:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_rd;

  modport master (
    output in_valid, in_funct3, in_rs1, in_rs2, in_rd, out_ready,
    input  in_ready, out_valid, out_data, out_rd
  );

  modport slave (
    input  in_valid, in_funct3, in_rs1, in_rs2, in_rd, out_ready,
    output in_ready, out_valid, out_data, out_rd
  );
endinterface

// File: rtl/mul_issue_ctrl.sv
// RV32M multiply sequencer in front of the shared pipelined 33x33 multiplier.
// Optional result cache for back-to-back identical ops: define MUL_RESULT_REUSE_EN.
module mul_issue_ctrl #(
  parameter int unsigned LATENCY = 4
) (
  input  logic               clk,
  input  logic               rst,
  mul_issue_ctrl_if.slave    io,
  input  logic               flush,
  output logic               busy,
  output logic [31:0]        mul_a,
  output logic [31:0]        mul_b,
  output logic [2:0]         mul_ctrl,
  input  logic [31:0]        mul_y
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q;
  logic [31:0] a_q, b_q, data_q;
  logic [2:0]  ctrl_q;
  logic [4:0]  rd_q;

  logic        accept, capture, hit;
  logic [2:0]  in_ctrl;
  logic        funct3_unused;

  // bit 2 would select DIV/REM, which never reaches this block
  assign funct3_unused = io.in_funct3[2];

  // ctrl = {select high, B signed, A signed}
  function automatic logic [2:0] decode(input logic [1:0] f);
    logic [2:0] c;
    case (f)
      2'b00:   c = 3'b000;
      2'b01:   c = 3'b111;
      2'b10:   c = 3'b101;
      default: c = 3'b100;
    endcase
    return c;
  endfunction

  assign in_ctrl = decode(io.in_funct3[1:0]);

`ifdef MUL_RESULT_REUSE_EN
  logic        last_vld_q;
  logic [31:0] last_a_q, last_b_q, last_y_q;
  logic [2:0]  last_ctrl_q;

  // ctrl decode is one-to-one on funct3[1:0], so comparing ctrl compares funct3
  assign hit = last_vld_q && (io.in_rs1 == last_a_q) && (io.in_rs2 == last_b_q)
               && (in_ctrl == last_ctrl_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_vld_q  <= 1'b0;
      last_a_q    <= '0;
      last_b_q    <= '0;
      last_y_q    <= '0;
      last_ctrl_q <= '0;
    end else if (flush) begin
      last_vld_q  <= 1'b0;
    end else if (capture) begin
      last_vld_q  <= 1'b1;
      last_a_q    <= a_q;
      last_b_q    <= b_q;
      last_y_q    <= mul_y;
      last_ctrl_q <= ctrl_q;
    end
  end
`else
  assign hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    accept       = 1'b0;
    capture      = 1'b0;
    io.in_ready  = 1'b0;
    io.out_valid = 1'b0;
    busy         = 1'b1;
    case (state_q)
      S_IDLE: begin
        io.in_ready = 1'b1;
        busy        = 1'b0;
        if (io.in_valid && !flush) begin
          accept  = 1'b1;
          state_d = hit ? S_DONE : S_BUSY;
        end
      end
      S_BUSY: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (cnt_q == 4'd1) begin
          capture = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        io.out_valid = 1'b1;
        // a coincident handshake still delivers; flush alone discards
        if (io.out_ready || flush) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      ctrl_q <= '0;
      rd_q   <= '0;
      data_q <= '0;
    end else begin
      if (accept) rd_q <= io.in_rd;
      if (accept && !hit) begin
        a_q    <= io.in_rs1;
        b_q    <= io.in_rs2;
        ctrl_q <= in_ctrl;
        cnt_q  <= 4'(LATENCY);
      end else if (state_q == S_BUSY) begin
        cnt_q  <= cnt_q - 4'd1;
      end
      if (capture) data_q <= mul_y;
`ifdef MUL_RESULT_REUSE_EN
      if (accept && hit) data_q <= last_y_q;
`endif
    end
  end

  assign mul_a       = a_q;
  assign mul_b       = b_q;
  assign mul_ctrl    = ctrl_q;
  assign io.out_data = data_q;
  assign io.out_rd   = rd_q;

endmodule

// File: doc/mul_issue_ctrl.md
Name: mul_issue_ctrl

Overview:
- Sequencer between the execute stage and the shared pipelined 33x33 multiplier datapath, for RV32M MUL/MULH/MULHSU/MULHU.
- Accepts one op via valid/ready, decodes funct3 into the multiplier's 3-bit ctrl and holds operands stable for the pipeline latency.
- Captures the selected 32-bit half and returns it with the destination tag via valid/ready.
- Asserts busy so the hazard unit can stall issue; supports flush from branch mispredict or trap.

Parameters:
- LATENCY, 4, clock edges from operands present at mul_a/mul_b to a valid mul_y; legal range 1..15.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  op request
- in_ready  out  1  controller can accept an op
- in_funct3  in  3  RV32M funct3; bit2 must be 0 and is ignored
- in_rs1  in  32  operand A
- in_rs2  in  32  operand B
- in_rd  in  5  destination register tag
- flush  in  1  abort the in-flight op and discard its result
- out_valid  out  1  result available
- out_ready  in  1  writeback accepts the result
- out_data  out  32  result
- out_rd  out  5  tag of the result
- busy  out  1  op accepted and not yet retired
- mul_a  out  32  multiplier operand A
- mul_b  out  32  multiplier operand B
- mul_ctrl  out  3  [0] A signed, [1] B signed, [2] select high word
- mul_y  in  32  multiplier result

Behaviour:
- Decode of funct3[1:0] to mul_ctrl:
  - 00 MUL gives 000
  - 01 MULH gives 111
  - 10 MULHSU gives 101
  - 11 MULHU gives 100
- States:
  - IDLE: in_ready=1.
  - BUSY: counter running.
  - DONE: out_valid=1.
- Accept: in_valid&&in_ready&&!flush in IDLE, call it edge 0.
  - On edge 0, latch rs1, rs2, rd and the decoded ctrl into registers, load cnt=LATENCY, go to BUSY.
  - mul_a, mul_b and mul_ctrl are driven only from these registers, never combinationally from the in_* ports.
  - They are stable for the whole of BUSY and DONE and keep their values in IDLE.
- BUSY: cnt decrements every edge.
  - On the edge where cnt==1, capture mul_y into out_data and go to DONE.
  - out_valid is therefore first high in the cycle after edge LATENCY; with LATENCY=4 that is 5 cycles of latency.
- DONE: out_data and out_rd hold until out_valid&&out_ready, then return to IDLE.
  - A new op cannot be accepted in the handshake cycle; in_ready rises the next cycle.
  - Sustained throughput is one op per LATENCY+2 cycles.
- busy = (state != IDLE).
- Flush:
  - In BUSY or DONE, the next state is IDLE, out_valid drops next cycle and the result is discarded.
  - Flush together with in_valid in IDLE: no accept (flush wins).
  - Flush together with the out handshake: the handshake completes and the result counts as delivered.
- Reset, synchronous:
  - state=IDLE, cnt=0, out_valid=0, in_ready=1 the cycle after reset deasserts.
  - out_data=0, out_rd=0, mul_a=0, mul_b=0, mul_ctrl=000, busy=0.
  - Reset mid-operation aborts like flush with all registers cleared.
- in_funct3[2] is ignored; the decoder upstream guarantees no DIV/REM op reaches this block.
- LATENCY=1: one BUSY cycle, capture on the first edge after accept.

Optional Feature:
- Macro MUL_RESULT_REUSE_EN.
- When defined:
  - The block keeps a last_vld flag plus last rs1, rs2, funct3[1:0] and result.
  - An accepted op that matches all four fields with last_vld=1 skips BUSY: it goes straight to DONE with the cached result, so out_valid is high in cycle 1.
  - The multiplier registers are left unchanged on a hit.
  - last_vld is cleared by reset and by flush, and is set on every completed BUSY→DONE capture.
- When undefined: no cache registers; every op takes the full LATENCY+1 path.

Test Plan:
- LATENCY=4, MUL rs1=7, rs2=6, rd=3 → out_valid first high in cycle 5, out_data=0x0000002A, out_rd=3, mul_ctrl=000 throughout.
- MULH rs1=0xFFFFFFFF, rs2=0xFFFFFFFF → 0x00000000; MULHU with the same operands → 0xFFFFFFFE.
- MULHSU rs1=0xFFFFFFFF, rs2=2 → 0xFFFFFFFF, mul_ctrl=101; out_ready held low 3 cycles → out_data and out_rd stable, in_ready=0 until one cycle after the handshake.
- Flush in cycle 2 of a MUL → no out_valid, in_ready=1 next cycle; a following MUL 3*5 returns 15 with correct timing.
- rst asserted in BUSY → all outputs at reset values next cycle; in_valid held with rst high is not accepted.
- With MUL_RESULT_REUSE_EN: MULHU 0xFFFFFFFF*0xFFFFFFFF twice → the second returns 0xFFFFFFFE with out_valid in cycle 1. Then flush, then the same op again → full latency.
